// File: rtl/gemm_cfg_queue.sv
// rtl/gemm_cfg_queue.sv - GEMM tile descriptor staging registers and DEPTH-entry commit queue
// Optional completion counter at offset 0x20 is built when GEMM_CFG_DONE_CNT_EN is defined.
module gemm_cfg_queue #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          DEPTH     = 4,
  parameter int          SIZE_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              system_bus_en,
  input  logic              system_bus_rdwr,
  input  logic [31:0]       system_bus_wr_data,
  input  logic [31:0]       system_bus_addr,
  output logic [31:0]       system_bus_rd_data,
  input  logic              desc_pop,
  input  logic              gemm_done,
  output logic [31:0]       tile_A_addr,
  output logic [31:0]       tile_B_addr,
  output logic [31:0]       tile_C_addr,
  output logic [31:0]       tile_A_stride,
  output logic [31:0]       tile_B_stride,
  output logic [SIZE_W-1:0] msize,
  output logic [SIZE_W-1:0] ksize,
  output logic [SIZE_W-1:0] nsize,
  output logic              store,
  output logic              overwrite,
  output logic              conf_empty,
  output logic              conf_full
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          DIM_W    = 3 * SIZE_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [31:0] stage_a, stage_b, stage_c, stage_sa, stage_sb;
  logic        stage_store, stage_ovw;

  logic [31:0]      q_a    [DEPTH];
  logic [31:0]      q_b    [DEPTH];
  logic [31:0]      q_c    [DEPTH];
  logic [31:0]      q_sa   [DEPTH];
  logic [31:0]      q_sb   [DEPTH];
  logic [1:0]       q_ctrl [DEPTH];
  logic [DIM_W-1:0] q_dim  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          overflow;

  logic bus_wr, bus_rd;
  logic wr_a, wr_b, wr_c, wr_sa, wr_sb, wr_ctrl, wr_dim, wr_ovf_clr;
  logic do_push, do_pop, push_drop;

  assign bus_wr = system_bus_en & system_bus_rdwr;
  assign bus_rd = system_bus_en & ~system_bus_rdwr;

  assign wr_a       = bus_wr && (system_bus_addr == BASE_ADDR + 32'h00);
  assign wr_b       = bus_wr && (system_bus_addr == BASE_ADDR + 32'h04);
  assign wr_c       = bus_wr && (system_bus_addr == BASE_ADDR + 32'h08);
  assign wr_sa      = bus_wr && (system_bus_addr == BASE_ADDR + 32'h0C);
  assign wr_sb      = bus_wr && (system_bus_addr == BASE_ADDR + 32'h10);
  assign wr_ctrl    = bus_wr && (system_bus_addr == BASE_ADDR + 32'h14);
  assign wr_dim     = bus_wr && (system_bus_addr == BASE_ADDR + 32'h18);
  assign wr_ovf_clr = bus_wr && (system_bus_addr == BASE_ADDR + 32'h1C);

  assign conf_empty = (count == '0);
  assign conf_full  = (count == FULL_CNT);

  // A pop on a full queue frees the slot the coincident push needs.
  assign do_pop    = desc_pop && !conf_empty;
  assign do_push   = wr_dim && (!conf_full || desc_pop);
  assign push_drop = wr_dim && conf_full && !desc_pop;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_a     <= '0;
      stage_b     <= '0;
      stage_c     <= '0;
      stage_sa    <= '0;
      stage_sb    <= '0;
      stage_store <= 1'b0;
      stage_ovw   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_a)    stage_a  <= system_bus_wr_data;
      if (wr_b)    stage_b  <= system_bus_wr_data;
      if (wr_c)    stage_c  <= system_bus_wr_data;
      if (wr_sa)   stage_sa <= system_bus_wr_data;
      if (wr_sb)   stage_sb <= system_bus_wr_data;
      if (wr_ctrl) begin
        stage_store <= system_bus_wr_data[0];
        stage_ovw   <= system_bus_wr_data[1];
      end
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (push_drop)       overflow <= 1'b1;
      else if (wr_ovf_clr) overflow <= 1'b0;
    end
  end

  // Entry storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      q_a[wr_ptr]    <= stage_a;
      q_b[wr_ptr]    <= stage_b;
      q_c[wr_ptr]    <= stage_c;
      q_sa[wr_ptr]   <= stage_sa;
      q_sb[wr_ptr]   <= stage_sb;
      q_ctrl[wr_ptr] <= {stage_ovw, stage_store};
      q_dim[wr_ptr]  <= system_bus_wr_data[DIM_W-1:0];
    end
  end

  always_comb begin
    tile_A_addr   = '0;
    tile_B_addr   = '0;
    tile_C_addr   = '0;
    tile_A_stride = '0;
    tile_B_stride = '0;
    store         = 1'b0;
    overwrite     = 1'b0;
    msize         = '0;
    ksize         = '0;
    nsize         = '0;
    if (!conf_empty) begin
      tile_A_addr   = q_a[rd_ptr];
      tile_B_addr   = q_b[rd_ptr];
      tile_C_addr   = q_c[rd_ptr];
      tile_A_stride = q_sa[rd_ptr];
      tile_B_stride = q_sb[rd_ptr];
      store         = q_ctrl[rd_ptr][0];
      overwrite     = q_ctrl[rd_ptr][1];
      msize         = q_dim[rd_ptr][SIZE_W-1:0];
      ksize         = q_dim[rd_ptr][2*SIZE_W-1:SIZE_W];
      nsize         = q_dim[rd_ptr][3*SIZE_W-1:2*SIZE_W];
    end
  end

`ifdef GEMM_CFG_DONE_CNT_EN
  logic [31:0] done_cnt;
  logic        wr_done_clr;

  assign wr_done_clr = bus_wr && (system_bus_addr == BASE_ADDR + 32'h20);

  always_ff @(posedge clk) begin
    if (rst || wr_done_clr) done_cnt <= '0;
    else if (gemm_done)     done_cnt <= done_cnt + 32'd1;
  end
`else
  logic unused_gemm_done;
  assign unused_gemm_done = gemm_done;
`endif

  always_comb begin
    system_bus_rd_data = '0;
    if (bus_rd) begin
      if (system_bus_addr == BASE_ADDR + 32'h00)
        system_bus_rd_data = {16'b0, 8'(count), 5'b0, overflow, conf_empty, conf_full};
      else if (system_bus_addr == BASE_ADDR + 32'h18)
        system_bus_rd_data = {31'b0, conf_empty};
`ifdef GEMM_CFG_DONE_CNT_EN
      else if (system_bus_addr == BASE_ADDR + 32'h20)
        system_bus_rd_data = done_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_gemm_cfg_queue.sv
// tb/tb_gemm_cfg_queue.sv - scoreboard bench for gemm_cfg_queue (DEPTH=4, SIZE_W=5)
module tb_gemm_cfg_queue;

  localparam logic [31:0] BASE = 32'h9000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_en, bus_rdwr, desc_pop, gemm_done;
  logic [31:0] bus_wr_data, bus_addr, bus_rd_data;
  logic [31:0] a_addr, b_addr, c_addr, a_stride, b_stride;
  logic [4:0]  msize, ksize, nsize;
  logic        store, overwrite, conf_empty, conf_full;

  gemm_cfg_queue #(.BASE_ADDR(BASE), .DEPTH(4), .SIZE_W(5)) dut (
    .clk(clk), .rst(rst),
    .system_bus_en(bus_en), .system_bus_rdwr(bus_rdwr),
    .system_bus_wr_data(bus_wr_data), .system_bus_addr(bus_addr),
    .system_bus_rd_data(bus_rd_data),
    .desc_pop(desc_pop), .gemm_done(gemm_done),
    .tile_A_addr(a_addr), .tile_B_addr(b_addr), .tile_C_addr(c_addr),
    .tile_A_stride(a_stride), .tile_B_stride(b_stride),
    .msize(msize), .ksize(ksize), .nsize(nsize),
    .store(store), .overwrite(overwrite),
    .conf_empty(conf_empty), .conf_full(conf_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a, b, c, sa, sb;
    logic        st, ow;
    logic [14:0] dim;
  } desc_t;

  desc_t sb_q[$];
  desc_t stage;
  logic  ovf_m;
  int    checks = 0;
  int    errors = 0;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic wr, input logic [31:0] off, input logic [31:0] data,
                       input logic pop, input logic done);
    @(negedge clk);
    bus_en = 1'b1; bus_rdwr = wr; bus_addr = BASE + off; bus_wr_data = data;
    desc_pop = pop; gemm_done = done;
    @(posedge clk);
    #1;
    bus_en = 1'b0; bus_rdwr = 1'b0; bus_addr = '0; bus_wr_data = '0;
    desc_pop = 1'b0; gemm_done = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d);
    @(negedge clk);
    bus_en = 1'b1; bus_rdwr = 1'b0; bus_addr = BASE + off;
    #1 d = bus_rd_data;
    bus_en = 1'b0; bus_addr = '0;
  endtask

  task automatic check_head(input string tag);
    desc_t e;
    e = (sb_q.size() == 0) ? '0 : sb_q[0];
    check({tag, ".A"},    a_addr,   e.a);
    check({tag, ".B"},    b_addr,   e.b);
    check({tag, ".C"},    c_addr,   e.c);
    check({tag, ".SA"},   a_stride, e.sa);
    check({tag, ".SB"},   b_stride, e.sb);
    check({tag, ".ctrl"}, {30'b0, overwrite, store}, {30'b0, e.ow, e.st});
    check({tag, ".dim"},  {17'b0, nsize, ksize, msize}, {17'b0, e.dim});
    check({tag, ".empty"}, {31'b0, conf_empty}, {31'b0, sb_q.size() == 0});
    check({tag, ".full"},  {31'b0, conf_full},  {31'b0, sb_q.size() == 4});
  endtask

  task automatic check_status(input string tag);
    logic [31:0] exp;
    exp = {16'b0, 8'(sb_q.size()), 5'b0, ovf_m, sb_q.size() == 0, sb_q.size() == 4};
    bus_read(32'h00, rd);
    check({tag, ".status"}, rd, exp);
  endtask

  task automatic set_stage(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] sa, input logic [31:0] sbv, input logic [1:0] ctrl);
    cycle(1'b1, 32'h00, a, 1'b0, 1'b0);
    cycle(1'b1, 32'h04, b, 1'b0, 1'b0);
    cycle(1'b1, 32'h08, c, 1'b0, 1'b0);
    cycle(1'b1, 32'h0C, sa, 1'b0, 1'b0);
    cycle(1'b1, 32'h10, sbv, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, {30'b0, ctrl}, 1'b0, 1'b0);
    stage.a = a; stage.b = b; stage.c = c; stage.sa = sa; stage.sb = sbv;
    stage.st = ctrl[0]; stage.ow = ctrl[1];
  endtask

  task automatic commit(input logic [14:0] dim, input logic pop);
    desc_t d;
    int    sz;
    if (pop) check_head("pre_cpop");
    cycle(1'b1, 32'h18, {17'b0, dim}, pop, 1'b0);
    d = stage; d.dim = dim;
    sz = sb_q.size();
    if (pop && sz > 0) void'(sb_q.pop_front());
    if (sz < 4 || pop) sb_q.push_back(d);
    else ovf_m = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    check_head(tag);
    cycle(1'b0, 32'h3C, 32'h0, 1'b1, 1'b0);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
  endtask

  initial begin
    bus_en = 0; bus_rdwr = 0; bus_addr = 0; bus_wr_data = 0; desc_pop = 0; gemm_done = 0;
    stage = '0; ovf_m = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    bus_read(32'h00, rd);  check("rst.status", rd, 32'h0000_0002);
    bus_read(32'h18, rd);  check("rst.poll", rd, 32'h0000_0001);
    #2 check("rst.idle_rd", bus_rd_data, 32'h0);
    check_head("rst");

    set_stage(32'h1000, 32'h2000, 32'h3000, 32'd16, 32'd32, 2'b11);
    commit(15'h2C64, 1'b0);
    check("first.msize", {27'b0, msize}, 32'd4);
    check("first.ksize", {27'b0, ksize}, 32'd3);
    check("first.nsize", {27'b0, nsize}, 32'd11);
    check_head("first");
    bus_read(32'h00, rd);  check("first.status", rd, 32'h0000_0100);

    for (int i = 1; i < 5; i++) begin
      cycle(1'b1, 32'h00, 32'h1000 + 32'(i) * 32'h100, 1'b0, 1'b0);
      stage.a = 32'h1000 + 32'(i) * 32'h100;
      commit(15'(i * 37 + 1), 1'b0);
      check_head($sformatf("fill%0d", i));
    end
    bus_read(32'h00, rd);  check("ovf.status", rd, 32'h0000_0405);
    cycle(1'b1, 32'h1C, 32'h0, 1'b0, 1'b0);
    ovf_m = 1'b0;
    bus_read(32'h00, rd);  check("ovfclr.status", rd, 32'h0000_0401);

    set_stage(32'hABCD_0000, 32'h5555_AAAA, 32'h0BAD_F00D, 32'd64, 32'd128, 2'b01);
    commit(15'h7FFF, 1'b1);
    check_status("fullpp");
    for (int i = 0; i < 4; i++) pop_one($sformatf("drain%0d", i));
    check_status("drained");
    pop_one("pop_empty");
    check_status("pop_empty");

    for (int i = 0; i < 3; i++) begin
      set_stage(32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                2'($urandom_range(0, 3)));
      commit(15'($urandom), 1'b0);
    end
    check_status("wrap3");
    for (int i = 0; i < 3; i++) pop_one($sformatf("wrap%0d", i));
    check_head("wrap_end");

    commit(15'h1234, 1'b1);
    check_status("empty_pp");
    check_head("empty_pp");

    commit(15'h0421, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete(); stage = '0; ovf_m = 1'b0;
    check_head("midrst");
    check_status("midrst");
    commit(15'h0001, 1'b0);
    check_head("post_rst_stage");

    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h3C, 32'h0, 1'b0, 1'b1);
    bus_read(32'h20, rd);
`ifdef GEMM_CFG_DONE_CNT_EN
    check("done.cnt3", rd, 32'd3);
`else
    check("done.off", rd, 32'd0);
`endif
    cycle(1'b1, 32'h20, 32'hFFFF_FFFF, 1'b0, 1'b1);
    bus_read(32'h20, rd);
    check("done.clr_wins", rd, 32'd0);
    bus_read(32'h24, rd);
    check("unmapped", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
